wb_port_arbiter: RTL and testbench

- Owns the single write port of the register file. It merges writeback-stage results with results from the long-latency multiply/divide unit.
- Pipeline writeback always has priority. Long-latency results wait in a small age-ordered queue and drain into idle write slots.
- Exports pending-write hazard flags so decode can stall reads of registers whose value is still queued.

---
 rtl/wb_port_arbiter.sv | 134 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_port_arbiter
// Purpose  : Register-file write-port arbiter. Pipeline writeback wins and
//            long-latency results queue and drain into idle slots.
// Revision : 1.0 - initial release
// ============================================================================
module wb_port_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        lu_valid,
  input  logic [4:0]  lu_rd,
  input  logic [31:0] lu_data,
  output logic        lu_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        pend1,
  output logic        pend2,
  output logic        RegWrite,
  output logic [4:0]  Write_register,
  output logic [31:0] Write_data,
  output logic [2:0]  q_count
);

  localparam logic [2:0] c_depth = 3'(DEPTH);

  logic [DEPTH-1:0] r_vld;
  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [2:0]       r_count;

  logic [DEPTH-1:0] w_vld_nxt;
  logic [4:0]       w_rd_nxt   [DEPTH];
  logic [31:0]      w_data_nxt [DEPTH];
  logic [2:0]       w_count_nxt;

  logic w_wb_win;
  logic w_drain;
  logic w_accept;

  // A register-0 destination is never a real write on either source.
  assign w_wb_win = wb_valid && (wb_rd != 5'd0);
  assign w_drain  = !w_wb_win && (r_count != 3'd0);
  assign lu_ready = (r_count < c_depth) && !reset;
  assign w_accept = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign q_count  = r_count;

  // Drop the drained head and WAW-cancelled entries, compact survivors in
  // age order, then append the accepted transfer at the new tail.
  always_comb begin : p_next
    int   n;
    logic keep;
    n    = 0;
    keep = 1'b0;
    for (int j = 0; j < DEPTH; j++) begin
      w_vld_nxt[j]  = 1'b0;
      w_rd_nxt[j]   = 5'd0;
      w_data_nxt[j] = 32'd0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      keep = r_vld[i] && !(w_drain && (i == 0)) &&
             !(w_wb_win && (r_rd[i] == wb_rd));
      if (keep) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (j == n) begin
            w_vld_nxt[j]  = 1'b1;
            w_rd_nxt[j]   = r_rd[i];
            w_data_nxt[j] = r_data[i];
          end
        end
        n = n + 1;
      end
    end
    if (w_accept) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j == n) begin
          w_vld_nxt[j]  = 1'b1;
          w_rd_nxt[j]   = lu_rd;
          w_data_nxt[j] = lu_data;
        end
      end
      n = n + 1;
    end
    w_count_nxt = 3'(n);
  end

  always_comb begin : p_pend
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i] && (r_rd[i] == rs1) && (rs1 != 5'd0)) pend1 = 1'b1;
      if (r_vld[i] && (r_rd[i] == rs2) && (rs2 != 5'd0)) pend2 = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld          <= '0;
      r_count        <= 3'd0;
      RegWrite       <= 1'b0;
      Write_register <= 5'd0;
      Write_data     <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= 5'd0;
        r_data[i] <= 32'd0;
      end
    end else begin
      r_vld   <= w_vld_nxt;
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= w_rd_nxt[i];
        r_data[i] <= w_data_nxt[i];
      end
      if (w_wb_win) begin
        RegWrite       <= 1'b1;
        Write_register <= wb_rd;
        Write_data     <= wb_data;
      end else if (w_drain) begin
        RegWrite       <= 1'b1;
        Write_register <= r_rd[0];
        Write_data     <= r_data[0];
      end else begin
        RegWrite <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_port_arbiter
// Purpose  : Directed self-checking bench for wb_port_arbiter with a
//            write-port scoreboard of expected {rd, data} pairs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        pend1;
  logic        pend2;
  logic        RegWrite;
  logic [4:0]  Write_register;
  logic [31:0] Write_data;
  logic [2:0]  q_count;

  int vectors     = 0;
  int miscompares = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rs1(rs1), .rs2(rs2), .pend1(pend1), .pend2(pend2),
    .RegWrite(RegWrite), .Write_register(Write_register),
    .Write_data(Write_data), .q_count(q_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, sample 1ns later and score any emitted write.
  task automatic tick();
    logic [36:0] e;
    @(posedge clk);
    #1;
    if (RegWrite === 1'b1) begin
      chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("write_rd_data", {27'd0, Write_register, Write_data}, {27'd0, e});
      end
    end
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v; wb_rd = rd; wb_data = d;
    if (v && rd != 5'd0) exp_q.push_back({rd, d});
  endtask

  task automatic lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    lu_valid = v; lu_rd = rd; lu_data = d;
  endtask

  initial begin
    reset = 1'b1; rs1 = 5'd0; rs2 = 5'd0;
    wb(1'b0, 5'd0, 32'd0);
    lu(1'b1, 5'd7, 32'hDEAD);

    // Reset with an offer pending
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_lu_ready", 64'(lu_ready), 64'd0);
      chk("rst_regwrite", 64'(RegWrite), 64'd0);
      chk("rst_q_count", 64'(q_count), 64'd0);
      chk("rst_pend1", 64'(pend1), 64'd0);
    end
    chk("rst_wreg", 64'(Write_register), 64'd0);
    chk("rst_wdata", 64'(Write_data), 64'd0);
    reset = 1'b0;
    lu(1'b0, 5'd0, 32'd0);
    #1;
    chk("rel_lu_ready", 64'(lu_ready), 64'd1);
    chk("rel_q_count", 64'(q_count), 64'd0);

    // WB only
    wb(1'b1, 5'd5, 32'h11223344);
    tick();
    chk("wb_regwrite", 64'(RegWrite), 64'd1);
    wb(1'b1, 5'd0, 32'hFFFF0000);
    tick();
    chk("wb_rd0_regwrite", 64'(RegWrite), 64'd0);
    chk("wb_hold_wreg", 64'(Write_register), 64'd5);
    chk("wb_hold_wdata", 64'(Write_data), 64'h11223344);

    // Queue fills while WB is busy, then drains in order
    wb(1'b1, 5'd1, 32'd100); lu(1'b1, 5'd8, 32'hA);
    tick();
    wb(1'b1, 5'd2, 32'd200); lu(1'b1, 5'd9, 32'hB);
    tick();
    wb(1'b1, 5'd3, 32'd300); lu(1'b1, 5'd10, 32'hC);
    rs1 = 5'd8; rs2 = 5'd9;
    tick();
    chk("full_q_count", 64'(q_count), 64'd2);
    chk("full_lu_ready", 64'(lu_ready), 64'd0);
    chk("full_pend1", 64'(pend1), 64'd1);
    chk("full_pend2", 64'(pend2), 64'd1);
    wb(1'b0, 5'd0, 32'd0); lu(1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd8, 32'hA});
    exp_q.push_back({5'd9, 32'hB});
    tick();
    chk("drain1_regwrite", 64'(RegWrite), 64'd1);
    chk("drain1_q_count", 64'(q_count), 64'd1);
    chk("drain1_pend1", 64'(pend1), 64'd0);
    chk("drain1_pend2", 64'(pend2), 64'd1);
    tick();
    chk("drain2_regwrite", 64'(RegWrite), 64'd1);
    chk("drain2_q_count", 64'(q_count), 64'd0);
    tick();
    chk("drain_idle", 64'(RegWrite), 64'd0);

    // WAW cancel of the only entry
    lu(1'b1, 5'd8, 32'h55);
    tick();
    lu(1'b0, 5'd0, 32'd0);
    chk("waw_q1", 64'(q_count), 64'd1);
    wb(1'b1, 5'd8, 32'h77);
    tick();
    chk("waw_q0", 64'(q_count), 64'd0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    chk("waw_no_stale", 64'(RegWrite), 64'd0);

    // WAW cancel of a non-head entry, survivor keeps its place
    wb(1'b1, 5'd12, 32'h120); lu(1'b1, 5'd9, 32'h91);
    tick();
    wb(1'b1, 5'd13, 32'h130); lu(1'b1, 5'd8, 32'h81);
    tick();
    chk("waw2_q2", 64'(q_count), 64'd2);
    wb(1'b1, 5'd8, 32'h88); lu(1'b0, 5'd0, 32'd0);
    tick();
    chk("waw2_q1", 64'(q_count), 64'd1);
    wb(1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd9, 32'h91});
    tick();
    chk("waw2_q0", 64'(q_count), 64'd0);

    // Drain and enqueue in the same edge
    lu(1'b1, 5'd3, 32'h33);
    tick();
    lu(1'b1, 5'd4, 32'h44);
    exp_q.push_back({5'd3, 32'h33});
    tick();
    chk("simul_q1", 64'(q_count), 64'd1);
    lu(1'b0, 5'd0, 32'd0);
    exp_q.push_back({5'd4, 32'h44});
    tick();
    chk("simul_q0", 64'(q_count), 64'd0);

    // Same-edge enqueue is not cancelled; rd=0 offers are discarded
    wb(1'b1, 5'd6, 32'h600); lu(1'b1, 5'd6, 32'h601);
    tick();
    chk("young_q1", 64'(q_count), 64'd1);
    wb(1'b0, 5'd0, 32'd0); lu(1'b1, 5'd0, 32'h999);
    exp_q.push_back({5'd6, 32'h601});
    tick();
    chk("rd0_q0", 64'(q_count), 64'd0);
    lu(1'b0, 5'd0, 32'd0);
    tick();
    chk("rd0_no_write", 64'(RegWrite), 64'd0);

    // Reset mid-operation discards a full queue
    wb(1'b1, 5'd14, 32'h140); lu(1'b1, 5'd20, 32'h20);
    tick();
    wb(1'b1, 5'd15, 32'h150); lu(1'b1, 5'd21, 32'h21);
    tick();
    chk("pre_rst_q2", 64'(q_count), 64'd2);
    wb(1'b0, 5'd0, 32'd0); lu(1'b0, 5'd0, 32'd0);
    reset = 1'b1;
    tick();
    chk("mid_rst_q0", 64'(q_count), 64'd0);
    chk("mid_rst_lu_ready", 64'(lu_ready), 64'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_idle", 64'(RegWrite), 64'd0);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
